cim_accum_mem: RTL
==================

Name: cim_accum_mem

Overview:
Parametrised N-channel compute-in-memory tile accumulator. Each channel takes 6x6 signed Winograd output tiles from a PE and performs a pipelined read-modify-write, saturating-add into a per-address accumulator memory. The block replaces the dual-clock-phase PE/CIM muxing with a single-clock valid/ready pipeline that has hazard forwarding. A shared off-chip scan port provides write, read and bulk-clear access.

Parameters:
N_CH, 2, number of independent PE/accumulator channels
DEPTH, 256, accumulator entries per channel
ADDR_W, 8, address width (DEPTH = 2**ADDR_W)
ELEM_W, 12, signed element width
TILE_N, 36, elements per tile (6x6, row-major, element k at bits [k*ELEM_W +: ELEM_W])
SCAN_W, 512, scan bus width (must be >= TILE_N*ELEM_W; upper bits zero-padded)

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high
pe_tile_i  in  N_CH*TILE_N*ELEM_W  packed tiles; channel c at [c*TILE_N*ELEM_W +: TILE_N*ELEM_W]
pe_addr_i  in  N_CH*ADDR_W  per-channel accumulate address
pe_valid_i  in  N_CH  per-channel tile valid
pe_ready_o  out  N_CH  per-channel accept
scan_start_i  in  1  one-cycle command strobe
scan_mode_i  in  2  00 nop, 01 write, 10 read, 11 clear-all
scan_ch_i  in  $clog2(N_CH)  target channel (ignored for clear)
scan_addr_i  in  ADDR_W  target address
scan_in  in  SCAN_W  write data
scan_out  out  SCAN_W  read data, zero-padded
scan_valid_o  out  1  one-cycle pulse when scan_out is valid
busy_o  out  1  high in any state other than RUN
sat_flag_o  out  N_CH  sticky saturation flag
stats_o  out  N_CH*16  accepted-tile counters (see Optional Feature)

Behaviour:
- Reset: FSM to RUN. pe_ready_o = all 1, scan_out = 0, scan_valid_o = 0, busy_o = 0, sat_flag_o = 0, pipelines empty. Memory contents are undefined after reset; software issues clear-all.
- Handshake: a tile is accepted when pe_valid_i[c] & pe_ready_o[c]. pe_ready_o[c] = (state == RUN) for all channels. Each channel accepts one tile per cycle and channels are fully independent.
- Pipeline per channel:
  - Cycle t: accept, then register addr and tile into S1.
  - Cycle t+1: read mem[addr] and add elementwise, then register addr and sum into S2.
  - Cycle t+2: write mem[addr] = sum.
- Forwarding: if S1 and S2 are both valid with equal addr, the S2 sum replaces the memory operand. Back-to-back tiles to the same address must accumulate exactly.
- Arithmetic: each element sum is computed at ELEM_W+1 bits and clamped to [-2**(ELEM_W-1), 2**(ELEM_W-1)-1]. Any clamp sets sat_flag_o[c], which stays set until reset or clear-all.
- FSM states: RUN, DRAIN, SCAN_WR, SCAN_RD, CLEAR.
  - RUN: scan_start_i latches mode, channel and address, then goes to DRAIN. Mode 00 is ignored and stays in RUN.
  - DRAIN: ready low; wait until every S1 and S2 is empty (at most 2 cycles), then go to SCAN_WR, SCAN_RD or CLEAR per the latched mode.
  - SCAN_WR: mem[ch][addr] = scan_in[TILE_N*ELEM_W-1:0] in one cycle, then RUN.
  - SCAN_RD: scan_out registered with the tile; scan_valid_o pulses the same cycle that scan_out updates; then RUN. scan_out holds its value until the next read.
  - CLEAR: counter runs 0..DEPTH-1 and writes zero to that index in all channels in parallel, DEPTH cycles; clears sat_flag_o and stats; then RUN.
- scan_start_i while busy_o = 1 is ignored.
- Reset asserted mid-operation aborts any in-flight tile and scan immediately. A partially completed CLEAR leaves memory undefined.
- Out-of-range scan_ch_i: a write is dropped and a read returns zeros with scan_valid_o still pulsed.

Optional Feature:
- Macro CIM_ACC_STATS_EN.
- Defined: per-channel 16-bit counter increments on each accepted tile, saturates at 0xFFFF, and is cleared by reset and clear-all. Counter c drives stats_o[c*16 +: 16].
- Undefined: no counters are built and stats_o is tied to 0. The port list is identical in both builds.

Test Plan:
- Clear-all, then scan read ch0 addr 5 -> scan_out = 0. busy_o high for exactly DEPTH+DRAIN cycles; scan_valid_o pulses once.
- Ch0 accepts an all-+3 tile at addr 7 on 4 consecutive cycles (forwarding path) -> scan read gives every element = 12.
- Scan write ch1 addr 2 with all elements 2000, then accumulate an all-+100 tile -> elements clamp to 2047 and sat_flag_o[1] = 1 while sat_flag_o[0] = 0. A subsequent clear-all drops sat_flag_o[1] to 0.
- Ch0 and ch1 both stream 10 tiles to addr 1 with element value 1 and -1 respectively -> ch0 elements = 10, ch1 elements = -10, no cross-talk between channels.
- scan_start_i read issued while both pipelines are full -> pe_ready_o drops the next cycle, in-flight writes land first, and the read returns post-accumulate data.
- CIM_ACC_STATS_EN build: 5 accepted tiles on ch0 with 2 stall cycles -> stats_o[15:0] = 5. Non-EN build: stats_o = 0.

Source files
------------

// File: rtl/cim_accum_mem.sv
// ---------------------------------------------------------------------------
// cim_accum_mem -- N-channel compute-in-memory tile accumulator.
//
// Each channel accepts one 6x6 signed tile per cycle and does a 3-stage
// read-modify-write: accept into S1, read mem and saturating-add into S2,
// then write back. A tile in S1 whose address matches the one in S2 takes
// the S2 sum instead of the stale memory word, so back-to-back tiles to the
// same address accumulate exactly. A shared scan port can write, read and
// bulk-clear the memories. The PE pipelines are drained before any scan
// access.
//
// Optional build macro: CIM_ACC_STATS_EN adds a 16-bit saturating
// accepted-tile counter per channel. Without it, stats_o is tied to zero.
//
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   pe_tile_i       packed tiles, channel c at [c*TILE_N*ELEM_W +: TILE_N*ELEM_W]
//   pe_addr_i       per-channel accumulate address
//   pe_valid_i      per-channel tile valid
//   pe_ready_o      per-channel accept (high only in RUN)
//   scan_start_i    one-cycle command strobe (honoured only in RUN)
//   scan_mode_i     00 nop, 01 write, 10 read, 11 clear-all
//   scan_ch_i       target channel for write/read
//   scan_addr_i     target address for write/read
//   scan_in         write data, low TILE_N*ELEM_W bits used
//   scan_out        read data, zero-padded, held until the next read
//   scan_valid_o    one-cycle pulse when scan_out updates
//   busy_o          high in every state except RUN
//   sat_flag_o      sticky per-channel saturation flag
//   stats_o         per-channel accepted-tile counters (16 bits each)
// ---------------------------------------------------------------------------
module cim_accum_mem #(
    parameter int N_CH   = 2,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8,
    parameter int ELEM_W = 12,
    parameter int TILE_N = 36,
    parameter int SCAN_W = 512,
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [N_CH*TILE_N*ELEM_W-1:0]   pe_tile_i,
    input  logic [N_CH*ADDR_W-1:0]          pe_addr_i,
    input  logic [N_CH-1:0]                 pe_valid_i,
    output logic [N_CH-1:0]                 pe_ready_o,
    input  logic                            scan_start_i,
    input  logic [1:0]                      scan_mode_i,
    input  logic [CH_W-1:0]                 scan_ch_i,
    input  logic [ADDR_W-1:0]               scan_addr_i,
    input  logic [SCAN_W-1:0]               scan_in,
    output logic [SCAN_W-1:0]               scan_out,
    output logic                            scan_valid_o,
    output logic                            busy_o,
    output logic [N_CH-1:0]                 sat_flag_o,
    output logic [N_CH*16-1:0]              stats_o
);

    localparam int TILE_W = TILE_N * ELEM_W;
    localparam logic [ELEM_W-1:0] ELEM_MAX = {1'b0, {(ELEM_W-1){1'b1}}};
    localparam logic [ELEM_W-1:0] ELEM_MIN = {1'b1, {(ELEM_W-1){1'b0}}};
    localparam logic [CH_W:0]     N_CH_CMP = (CH_W+1)'(N_CH);

    typedef enum logic [2:0] {
        ST_RUN, ST_DRAIN, ST_SCAN_WR, ST_SCAN_RD, ST_CLEAR
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          mode_q;
    logic [CH_W-1:0]     ch_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   clr_cnt_q;
    logic [SCAN_W-1:0]   scan_out_q;
    logic                scan_valid_q;
    logic                run;
    logic                ch_ok;
    logic [N_CH-1:0]     s1_valid_vec;
    logic [N_CH-1:0]     accept_vec;
    logic [TILE_W-1:0]   rd_data [N_CH];

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_RUN;
        else       state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:
                if (scan_start_i && scan_mode_i != 2'b00) state_d = ST_DRAIN;
            ST_DRAIN:
                // Once S1 is empty nothing new can enter; any S2 entry
                // retires its write on this same edge, so the scan state
                // entered next already sees fully updated memory.
                if (~|s1_valid_vec) begin
                    case (mode_q)
                        2'b01:   state_d = ST_SCAN_WR;
                        2'b10:   state_d = ST_SCAN_RD;
                        2'b11:   state_d = ST_CLEAR;
                        default: state_d = ST_RUN;
                    endcase
                end
            ST_SCAN_WR: state_d = ST_RUN;
            ST_SCAN_RD: state_d = ST_RUN;
            ST_CLEAR:
                if (clr_cnt_q == ADDR_W'(DEPTH-1)) state_d = ST_RUN;
            default:    state_d = ST_RUN;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        run        = (state_q == ST_RUN);
        pe_ready_o = {N_CH{run}};
        busy_o     = ~run;
    end

    // ---------------- scan control registers ----------------
    assign ch_ok = ({1'b0, ch_q} < N_CH_CMP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q       <= 2'b00;
            ch_q         <= '0;
            addr_q       <= '0;
            clr_cnt_q    <= '0;
            scan_out_q   <= '0;
            scan_valid_q <= 1'b0;
        end else begin
            scan_valid_q <= (state_q == ST_SCAN_RD);
            if (state_q == ST_RUN && scan_start_i) begin
                mode_q <= scan_mode_i;
                ch_q   <= scan_ch_i;
                addr_q <= scan_addr_i;
            end
            if (state_q == ST_SCAN_RD)
                scan_out_q <= ch_ok ? SCAN_W'(rd_data[ch_q]) : '0;
            clr_cnt_q <= (state_q == ST_CLEAR) ? clr_cnt_q + 1'b1 : '0;
        end
    end

    assign scan_out     = scan_out_q;
    assign scan_valid_o = scan_valid_q;

    // Padding bits of the scan write bus carry no data.
    if (SCAN_W > TILE_W) begin : g_pad
        logic scan_pad_unused;
        assign scan_pad_unused = ^scan_in[SCAN_W-1:TILE_W];
    end

    // ---------------- per-channel pipelines and memories ----------------
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        localparam logic [CH_W-1:0] MY_CH = CH_W'(gi);

        logic [TILE_W-1:0] mem [DEPTH];
        logic              s1_valid_q, s2_valid_q, sat_q;
        logic [ADDR_W-1:0] s1_addr_q, s2_addr_q;
        logic [TILE_W-1:0] s1_tile_q, s2_sum_q, s2_sum_d, operand;
        logic [TILE_N-1:0] clamp_vec;
        logic              wr_en;
        logic [ADDR_W-1:0] wr_addr;
        logic [TILE_W-1:0] wr_data;

        assign accept_vec[gi]   = pe_valid_i[gi] & run;
        assign s1_valid_vec[gi] = s1_valid_q;
        assign sat_flag_o[gi]   = sat_q;
        assign rd_data[gi]      = mem[addr_q];

        // Memory is read combinationally in the S1 cycle; S2 forwarding
        // covers the one write that has not landed yet.
        assign operand = (s2_valid_q && s2_addr_q == s1_addr_q) ? s2_sum_q
                                                                 : mem[s1_addr_q];

        for (genvar ei = 0; ei < TILE_N; ei++) begin : g_elem
            logic [ELEM_W-1:0] a_e, b_e;
            logic [ELEM_W:0]   wide;
            assign a_e  = s1_tile_q[ei*ELEM_W +: ELEM_W];
            assign b_e  = operand[ei*ELEM_W +: ELEM_W];
            assign wide = {a_e[ELEM_W-1], a_e} + {b_e[ELEM_W-1], b_e};
            // Top two bits disagree only when the sum left the ELEM_W range.
            assign clamp_vec[ei] = wide[ELEM_W] ^ wide[ELEM_W-1];
            assign s2_sum_d[ei*ELEM_W +: ELEM_W] =
                clamp_vec[ei] ? (wide[ELEM_W] ? ELEM_MIN : ELEM_MAX)
                              : wide[ELEM_W-1:0];
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                s1_valid_q <= 1'b0;
                s1_addr_q  <= '0;
                s1_tile_q  <= '0;
                s2_valid_q <= 1'b0;
                s2_addr_q  <= '0;
                s2_sum_q   <= '0;
                sat_q      <= 1'b0;
            end else begin
                s1_valid_q <= accept_vec[gi];
                if (accept_vec[gi]) begin
                    s1_addr_q <= pe_addr_i[gi*ADDR_W +: ADDR_W];
                    s1_tile_q <= pe_tile_i[gi*TILE_W +: TILE_W];
                end
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_addr_q <= s1_addr_q;
                    s2_sum_q  <= s2_sum_d;
                end
                if (state_q == ST_CLEAR)
                    sat_q <= 1'b0;
                else if (s1_valid_q && |clamp_vec)
                    sat_q <= 1'b1;
            end
        end

        // Scan and clear accesses only happen with the pipeline drained,
        // so the three write sources never collide.
        always_comb begin
            wr_en   = s2_valid_q;
            wr_addr = s2_addr_q;
            wr_data = s2_sum_q;
            if (state_q == ST_CLEAR) begin
                wr_en   = 1'b1;
                wr_addr = clr_cnt_q;
                wr_data = '0;
            end else if (state_q == ST_SCAN_WR) begin
                wr_en   = ch_ok && (ch_q == MY_CH);
                wr_addr = addr_q;
                wr_data = scan_in[TILE_W-1:0];
            end
        end

        always_ff @(posedge clk) begin
            if (wr_en) mem[wr_addr] <= wr_data;
        end
    end

    // ---------------- optional accepted-tile counters ----------------
`ifdef CIM_ACC_STATS_EN
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_stats
        logic [15:0] stat_q;
        always_ff @(posedge clk or posedge reset) begin
            if (reset)
                stat_q <= 16'd0;
            else if (state_q == ST_CLEAR)
                stat_q <= 16'd0;
            else if (accept_vec[gi] && stat_q != 16'hFFFF)
                stat_q <= stat_q + 16'd1;
        end
        assign stats_o[gi*16 +: 16] = stat_q;
    end
`else
    assign stats_o = '0;
`endif

endmodule
